// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: 5-stage pipeline control decode, load-use stall, flush bubbles and EX forwarding selects
module ctrl_pipe_hazard #(
  parameter int         REG_AW  = 5,
  parameter int         ALU_W   = 4,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b001101,
  parameter logic [5:0] OP_ADDI = 6'b001000,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter bit         FWD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              illegal,
  output logic              ex_valid,
  output logic              ex_alu_src,
  output logic [ALU_W-1:0]  ex_alu_ctrl,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dest
);
  typedef struct packed {
    logic              valid;
    logic              ill;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              m2r;
    logic              as;
    logic              br;
    logic              j;
    logic [ALU_W-1:0]  alu;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
  } ex_t;
  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              m2r;
    logic [REG_AW-1:0] dest;
  } mem_t;
  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              m2r;
    logic [REG_AW-1:0] dest;
  } wb_t;
  ex_t  dec, ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;
  logic uses_rt, load;
  logic fa_mem, fa_wb, fb_mem, fb_wb;
  // ID-stage decode of the incoming instruction into a full control bundle
  always_comb begin
    dec       = '0;
    uses_rt   = 1'b0;
    dec.valid = 1'b1;
    dec.rs    = id_rs;
    dec.rt    = id_rt;
    if (opcode == 6'b000000) begin
      uses_rt  = 1'b1;
      dec.rw   = 1'b1;
      dec.dest = id_rd;
      case (funct)
        6'b100000: dec.alu = ALU_W'(4'b0010);
        6'b100010: dec.alu = ALU_W'(4'b0110);
        6'b100100: dec.alu = ALU_W'(4'b0000);
        6'b100101: dec.alu = ALU_W'(4'b0001);
        6'b100110: dec.alu = ALU_W'(4'b0111);
        6'b101010: dec.alu = ALU_W'(4'b1000);
        default: begin
          dec.rw   = 1'b0;
          dec.dest = '0;
          dec.ill  = 1'b1;
        end
      endcase
    end else if (opcode == OP_LW) begin
      dec.rw   = 1'b1;
      dec.mr   = 1'b1;
      dec.m2r  = 1'b1;
      dec.as   = 1'b1;
      dec.alu  = ALU_W'(4'b0010);
      dec.dest = id_rt;
    end else if (opcode == OP_SW) begin
      uses_rt = 1'b1;
      dec.mw  = 1'b1;
      dec.as  = 1'b1;
      dec.alu = ALU_W'(4'b0010);
    end else if (opcode == OP_ADDI) begin
      dec.rw   = 1'b1;
      dec.as   = 1'b1;
      dec.alu  = ALU_W'(4'b0010);
      dec.dest = id_rt;
    end else if (opcode == OP_BEQ) begin
      uses_rt = 1'b1;
      dec.br  = 1'b1;
      dec.alu = ALU_W'(4'b0110);
    end else if (opcode == OP_J) begin
      dec.j = 1'b1;
    end else begin
      dec.ill = 1'b1;
    end
    if (dec.dest == '0) dec.rw = 1'b0;
  end
  assign stall = id_valid & ex_q.valid & ex_q.mr & (ex_q.dest != '0) &
                 ((ex_q.dest == id_rs) | (uses_rt & (ex_q.dest == id_rt)));
  assign load  = id_valid & ~flush & ~stall;
  assign ex_d  = load ? dec : '0;
  assign mem_d = '{ex_q.valid, ex_q.rw, ex_q.mr, ex_q.mw, ex_q.m2r, ex_q.dest};
  assign wb_d  = '{mem_q.valid, mem_q.rw, mem_q.m2r, mem_q.dest};
  // Pipeline registers; EX/MEM and MEM/WB advance unconditionally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end
  assign fa_mem    = mem_q.valid & mem_q.rw & (mem_q.dest != '0) & (mem_q.dest == ex_q.rs);
  assign fa_wb     = wb_q.valid & wb_q.rw & (wb_q.dest != '0) & (wb_q.dest == ex_q.rs);
  assign fb_mem    = mem_q.valid & mem_q.rw & (mem_q.dest != '0) & (mem_q.dest == ex_q.rt);
  assign fb_wb     = wb_q.valid & wb_q.rw & (wb_q.dest != '0) & (wb_q.dest == ex_q.rt);
  assign forward_a = !FWD_EN ? 2'b00 : fa_mem ? 2'b10 : fa_wb ? 2'b01 : 2'b00;
  assign forward_b = !FWD_EN ? 2'b00 : fb_mem ? 2'b10 : fb_wb ? 2'b01 : 2'b00;
  assign illegal       = ex_q.ill;
  assign ex_valid      = ex_q.valid;
  assign ex_alu_src    = ex_q.as;
  assign ex_alu_ctrl   = ex_q.alu;
  assign ex_branch     = ex_q.br;
  assign ex_jump       = ex_q.j;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dest       = ex_q.dest;
  assign mem_valid     = mem_q.valid;
  assign mem_read      = mem_q.mr;
  assign mem_write     = mem_q.mw;
  assign mem_dest      = mem_q.dest;
  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.rw;
  assign wb_mem_to_reg = wb_q.m2r;
  assign wb_dest       = wb_q.dest;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed scenario checks for the pipeline control unit
module tb_ctrl_pipe_hazard;
  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b001101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;
  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic stall, illegal, ex_valid, ex_alu_src, ex_branch, ex_jump;
  logic [3:0] ex_alu_ctrl;
  logic [4:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic [1:0] forward_a, forward_b;
  logic mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [47:0] all_out;
  int total = 0, passed = 0;
  ctrl_pipe_hazard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .stall(stall),
    .illegal(illegal), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .forward_a(forward_a), .forward_b(forward_b), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dest(mem_dest), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest)
  );
  assign all_out = {stall, illegal, ex_valid, ex_alu_src, ex_alu_ctrl, ex_branch, ex_jump, ex_rs, ex_rt,
                    ex_dest, forward_a, forward_b, mem_valid, mem_read, mem_write, mem_dest,
                    wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest};
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask
  task automatic idle(input int n);
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask
  task automatic test_reset;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd3);
    tick(); tick();
    total++; if (all_out !== 48'd0) $display("FAIL reset_outputs got %h exp 0", all_out); else passed++;
    rst = 1'b0;
    idle(1);
  endtask
  task automatic test_add;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL add_ex_valid got %0b exp 1", ex_valid); else passed++;
    total++; if (ex_alu_ctrl !== 4'b0010) $display("FAIL add_alu got %b exp 0010", ex_alu_ctrl); else passed++;
    total++; if (ex_dest !== 5'd3) $display("FAIL add_ex_dest got %0d exp 3", ex_dest); else passed++;
    total++; if (ex_alu_src !== 1'b0) $display("FAIL add_alu_src got %0b exp 0", ex_alu_src); else passed++;
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if ({mem_valid, mem_dest} !== {1'b1, 5'd3}) $display("FAIL add_mem got %0b/%0d exp 1/3", mem_valid, mem_dest); else passed++;
    tick();
    total++; if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest} !== {3'b110, 5'd3})
      $display("FAIL add_wb got v%0b rw%0b m2r%0b d%0d exp 1 1 0 3", wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest); else passed++;
    idle(3);
  endtask
  task automatic test_load_use;
    drive(1'b1, LW, 6'b0, 5'd1, 5'd4, 5'd0);
    tick();
    total++; if (ex_dest !== 5'd4) $display("FAIL lw_dest got %0d exp 4", ex_dest); else passed++;
    drive(1'b1, R, F_SUB, 5'd4, 5'd1, 5'd5);
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got %0b exp 1", stall); else passed++;
    tick();
    total++; if ({ex_valid, mem_read} !== 2'b01) $display("FAIL lu_bubble got ex_valid %0b mem_read %0b exp 0 1", ex_valid, mem_read); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL lu_stall_once got %0b exp 0", stall); else passed++;
    tick();
    total++; if ({ex_valid, ex_alu_ctrl, ex_dest} !== {1'b1, 4'b0110, 5'd5})
      $display("FAIL lu_sub_issue got v%0b alu%b d%0d exp 1 0110 5", ex_valid, ex_alu_ctrl, ex_dest); else passed++;
    total++; if ({forward_a, forward_b} !== 4'b0100) $display("FAIL lu_fwd got a%b b%b exp 01 00", forward_a, forward_b); else passed++;
    total++; if ({wb_mem_to_reg, wb_dest} !== {1'b1, 5'd4}) $display("FAIL lu_wb got m2r%0b d%0d exp 1 4", wb_mem_to_reg, wb_dest); else passed++;
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_no_dup got %0b exp 0", ex_valid); else passed++;
    idle(3);
  endtask
  task automatic test_forward;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd6);
    tick();
    drive(1'b1, R, F_XOR, 5'd6, 5'd6, 5'd7);
    total++; if (stall !== 1'b0) $display("FAIL fwd_no_stall got %0b exp 0", stall); else passed++;
    tick();
    total++; if ({forward_a, forward_b} !== 4'b1010) $display("FAIL fwd_xor got a%b b%b exp 10 10", forward_a, forward_b); else passed++;
    total++; if (ex_alu_ctrl !== 4'b0111) $display("FAIL xor_alu got %b exp 0111", ex_alu_ctrl); else passed++;
    idle(3);
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd8);
    tick();
    drive(1'b1, R, F_AND, 5'd8, 5'd1, 5'd8);
    tick();
    total++; if ({ex_alu_ctrl, forward_a, forward_b} !== {4'b0000, 2'b10, 2'b00})
      $display("FAIL and_fwd got alu%b a%b b%b exp 0000 10 00", ex_alu_ctrl, forward_a, forward_b); else passed++;
    drive(1'b1, R, F_SLT, 5'd8, 5'd8, 5'd9);
    tick();
    total++; if ({ex_alu_ctrl, forward_a, forward_b} !== {4'b1000, 2'b10, 2'b10})
      $display("FAIL slt_prio got alu%b a%b b%b exp 1000 10 10", ex_alu_ctrl, forward_a, forward_b); else passed++;
    idle(3);
  endtask
  task automatic test_flush;
    drive(1'b1, BEQ, 6'b0, 5'd1, 5'd2, 5'd0);
    tick();
    total++; if ({ex_branch, ex_alu_ctrl} !== {1'b1, 4'b0110}) $display("FAIL beq_ex got br%0b alu%b exp 1 0110", ex_branch, ex_alu_ctrl); else passed++;
    flush = 1'b1;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd11);
    tick();
    flush = 1'b0;
    total++; if ({ex_valid, ex_alu_ctrl, ex_dest} !== 10'd0) $display("FAIL flush_bubble got v%0b alu%b d%0d exp 0", ex_valid, ex_alu_ctrl, ex_dest); else passed++;
    idle(3);
    drive(1'b1, LW, 6'b0, 5'd1, 5'd10, 5'd0);
    tick();
    flush = 1'b1;
    drive(1'b1, R, F_ADD, 5'd10, 5'd2, 5'd12);
    total++; if (stall !== 1'b1) $display("FAIL flush_stall_out got %0b exp 1", stall); else passed++;
    tick();
    flush = 1'b0;
    total++; if ({ex_valid, illegal, mem_read} !== 3'b001) $display("FAIL flush_wins got v%0b ill%0b mr%0b exp 0 0 1", ex_valid, illegal, mem_read); else passed++;
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if ({ex_valid, mem_valid} !== 2'b00) $display("FAIL flush_no_dup got ex%0b mem%0b exp 0 0", ex_valid, mem_valid); else passed++;
    idle(3);
  endtask
  task automatic test_stall_cases;
    drive(1'b1, LW, 6'b0, 5'd1, 5'd11, 5'd0);
    tick();
    drive(1'b1, SW, 6'b0, 5'd1, 5'd11, 5'd0);
    total++; if (stall !== 1'b1) $display("FAIL sw_rt_stall got %0b exp 1", stall); else passed++;
    drive(1'b0, R, F_ADD, 5'd11, 5'd11, 5'd3);
    total++; if (stall !== 1'b0) $display("FAIL invalid_no_stall got %0b exp 0", stall); else passed++;
    drive(1'b1, ADDI, 6'b0, 5'd1, 5'd11, 5'd0);
    total++; if (stall !== 1'b0) $display("FAIL addi_rt_no_stall got %0b exp 0", stall); else passed++;
    tick();
    total++; if ({ex_alu_src, ex_dest, mem_read} !== {1'b1, 5'd11, 1'b1}) $display("FAIL addi_ex got as%0b d%0d mr%0b exp 1 11 1", ex_alu_src, ex_dest, mem_read); else passed++;
    drive(1'b1, SW, 6'b0, 5'd1, 5'd2, 5'd0);
    tick();
    total++; if (ex_alu_src !== 1'b1) $display("FAIL sw_alu_src got %0b exp 1", ex_alu_src); else passed++;
    drive(1'b1, J, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if ({ex_jump, mem_write, mem_read} !== 3'b110) $display("FAIL j_sw_mem got j%0b mw%0b mr%0b exp 1 1 0", ex_jump, mem_write, mem_read); else passed++;
    idle(3);
    drive(1'b1, LW, 6'b0, 5'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, R, F_ADD, 5'd0, 5'd0, 5'd5);
    total++; if (stall !== 1'b0) $display("FAIL lw_r0_no_stall got %0b exp 0", stall); else passed++;
    idle(3);
  endtask
  task automatic test_illegal;
    drive(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if ({illegal, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump} !== {1'b1, 7'd0})
      $display("FAIL illegal_op got ill%0b alu%b as%0b br%0b j%0b exp 1 0", illegal, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump); else passed++;
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if ({illegal, mem_read, mem_write} !== 3'b000) $display("FAIL illegal_clear got ill%0b mr%0b mw%0b exp 0", illegal, mem_read, mem_write); else passed++;
    drive(1'b1, R, 6'b000000, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if (illegal !== 1'b1) $display("FAIL illegal_funct got %0b exp 1", illegal); else passed++;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b0, R, 6'b0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    total++; if ({wb_valid, wb_reg_write} !== 2'b10) $display("FAIL r0_no_write got v%0b rw%0b exp 1 0", wb_valid, wb_reg_write); else passed++;
    idle(3);
  endtask
  task automatic test_async_reset;
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd4);
    tick();
    drive(1'b1, R, F_ADD, 5'd1, 5'd2, 5'd5);
    tick();
    total++; if ({ex_valid, mem_valid, wb_valid} !== 3'b111) $display("FAIL inflight got %b exp 111", {ex_valid, mem_valid, wb_valid}); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (all_out !== 48'd0) $display("FAIL async_reset got %h exp 0", all_out); else passed++;
    tick();
    total++; if (all_out !== 48'd0) $display("FAIL reset_hold got %h exp 0", all_out); else passed++;
    rst = 1'b0;
    idle(2);
  endtask
  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_forward();
    test_flush();
    test_stall_cases();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
